fact_unit: RTL

//  Multi-cycle factorial execution unit; responder side of the CU FACT/FACT_END handshake.
//  CU raises FACT during EX with the selected register (X or Y) on operand, and holds EX until FACT drops.

---
 rtl/fact_unit.sv | 128 ++++++++++++
 1 files changed

// File: rtl/fact_unit.sv
// fact_unit: multi-cycle unsigned factorial unit.
// It answers the CU FACT/FACT_END handshake and performs one multiply per cycle.
// The result and flags are registered. They change only on the edge that enters DONE.
module fact_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             FACT,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] result,
    output logic             FACT_END,
    output logic             busy,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL      = 2'd1,
        DONE     = 2'd2,
        WAIT_LOW = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] TWO = {{(WIDTH-2){1'b0}}, 2'b10};

    state_t             state;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   cnt;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   prod_lo;
    logic               prod_ovf;

    // The zero flag is derived from the value being loaded into result.
    function automatic logic is_zero(input logic [WIDTH-1:0] v);
        return (v == '0);
    endfunction

    // The full-width product keeps the high half, which is needed to detect overflow.
    assign prod     = {{WIDTH{1'b0}}, acc} * {{WIDTH{1'b0}}, cnt};
    assign prod_lo  = prod[WIDTH-1:0];
    assign prod_ovf = |prod[2*WIDTH-1:WIDTH];

    // Handshake FSM, iteration datapath and registered result/flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            acc      <= '0;
            cnt      <= '0;
            result   <= '0;
            FACT_END <= 1'b0;
            busy     <= 1'b0;
            zero     <= 1'b0;
            negative <= 1'b0;
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    FACT_END <= 1'b0;
                    if (FACT) begin
                        cnt  <= operand;
                        acc  <= ONE;
                        busy <= 1'b1;
                        if (operand <= ONE) begin
                            // 0! and 1! both complete immediately with result 1.
                            result   <= ONE;
                            zero     <= is_zero(ONE);
                            negative <= ONE[WIDTH-1];
                            carry    <= 1'b0;
                            overflow <= 1'b0;
                            FACT_END <= 1'b1;
                            state    <= DONE;
                        end else begin
                            state <= MUL;
                        end
                    end
                end
                MUL: begin
                    if (!FACT) begin
                        // The CU withdrew the request, so abort quietly and keep the old result.
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        acc <= prod_lo;
                        cnt <= cnt - ONE;
                        // Stop on the first overflowing step, or after the final *2 step.
                        if (prod_ovf || (cnt == TWO)) begin
                            result   <= prod_lo;
                            zero     <= is_zero(prod_lo);
                            negative <= prod_lo[WIDTH-1];
                            carry    <= prod_ovf;
                            overflow <= prod_ovf;
                            FACT_END <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                DONE: begin
                    FACT_END <= 1'b0;
                    if (FACT) begin
                        state <= WAIT_LOW;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                WAIT_LOW: begin
                    FACT_END <= 1'b0;
                    // Hold off any restart until FACT has been seen low.
                    if (!FACT) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    FACT_END <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
